// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, memory-wait freeze with timeout.
// Optional stall-cycle counter built only when HAZARD_PERF_CNT_EN is defined.
module hazard_flush_ctrl #(
  parameter int unsigned TIMEOUT = 200,
  parameter int unsigned WAIT_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_dst,
  input  logic        ex_branch_taken,
  input  logic        id_jump,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pipe_hold,
  output logic [1:0]  ctrl_state,
  output logic        timeout_err,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [WAIT_W-1:0] WAIT_TO  = WAIT_W'(TIMEOUT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              load_use;

  assign load_use = ex_memread && (ex_dst != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_dst)) ||
                     (id_uses_rt && (id_rt == ex_dst)));

  // Per-cycle control priority: freeze > redirect > load-use bubble > jump > run
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    if (mem_busy) begin
      pipe_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  // Memory-wait tracking
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_busy) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end else begin
          wait_cnt_nxt = '0;
        end
      end
      WAIT: begin
        if (mem_busy) begin
          if (wait_cnt != WAIT_MAX) wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  timeout_err <= 1'b0;
    else if (mem_busy && (wait_cnt == WAIT_TO)) timeout_err <= 1'b1;
  end

  assign ctrl_state = state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    stall_cnt <= '0;
    else if (!pc_write && (stall_cnt != '1))      stall_cnt <= stall_cnt + 32'd1;
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl against a cycle-level reference model.
module tb_hazard_flush_ctrl;
  localparam int unsigned TO = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_dst = '0;
  logic id_uses_rs = 0, id_uses_rt = 0, ex_memread = 0, ex_branch_taken = 0, id_jump = 0, mem_busy = 0;
  logic pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, timeout_err;
  logic [1:0] ctrl_state;
  logic [31:0] perf_stall_cnt;

  int total = 0, bad = 0;

  // reference model state
  int unsigned m_consec = 0;
  logic        m_tout = 0;
  logic [1:0]  m_state = 0;
  logic [31:0] m_perf = 0;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  hazard_flush_ctrl #(.TIMEOUT(TO), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_memread(ex_memread),
    .ex_dst(ex_dst), .ex_branch_taken(ex_branch_taken), .id_jump(id_jump),
    .mem_busy(mem_busy), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pipe_hold(pipe_hold),
    .ctrl_state(ctrl_state), .timeout_err(timeout_err), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  // expected {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}
  function automatic logic [4:0] model_ctl();
    bit lu;
    lu = ex_memread && ex_dst != 0 &&
         ((id_uses_rs && id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst));
    if (mem_busy)        return 5'b00001;
    if (ex_branch_taken) return 5'b11110;
    if (lu)              return 5'b00010;
    if (id_jump)         return 5'b11100;
    return 5'b11000;
  endfunction

  function automatic logic [4:0] got_ctl();
    return {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold};
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic mr, input logic [4:0] dst, input logic br, input logic jmp,
                       input logic busy);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt; ex_memread = mr;
    ex_dst = dst; ex_branch_taken = br; id_jump = jmp; mem_busy = busy;
    #1;
  endtask

  // advance one clock edge and update the model from the inputs seen at that edge
  task automatic tick();
    logic [4:0] e;
    e = model_ctl();
    @(posedge clk);
    if (reset) begin
      m_consec = 0; m_tout = 0; m_state = 0; m_perf = 0;
    end else begin
      if (PERF_EN && !e[4] && m_perf != 32'hFFFF_FFFF) m_perf++;
      if (mem_busy && m_consec == TO) m_tout = 1;
      m_consec = mem_busy ? m_consec + 1 : 0;
      m_state  = mem_busy ? 2'd1 : 2'd0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    total++; if (got_ctl() !== 5'b11000) begin bad++; $display("FAIL reset_ctl got=%b exp=11000", got_ctl()); end
    total++; if (ctrl_state !== 2'd0 || timeout_err !== 1'b0 || perf_stall_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_regs got st=%0d to=%b perf=%0d exp 0 0 0", ctrl_state, timeout_err, perf_stall_cnt);
    end
    @(negedge clk); reset = 0; #1;
  endtask

  task automatic test_load_use();
    drive(5'd5, 5'd9, 1, 1, 1, 5'd5, 0, 0, 0);
    total++; if (got_ctl() !== 5'b00010) begin bad++; $display("FAIL lu_stall got=%b exp=00010", got_ctl()); end
    tick();
    drive(5'd5, 5'd9, 1, 1, 0, 5'd0, 0, 0, 0);
    total++; if (got_ctl() !== 5'b11000) begin bad++; $display("FAIL lu_release got=%b exp=11000", got_ctl()); end
    total++; if (perf_stall_cnt !== (PERF_EN ? 32'd1 : 32'd0)) begin
      bad++; $display("FAIL lu_perf got=%0d exp=%0d", perf_stall_cnt, PERF_EN ? 1 : 0);
    end
    tick();
  endtask

  task automatic test_no_stall();
    drive(5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0);
    total++; if (got_ctl() !== 5'b11000) begin bad++; $display("FAIL dst_zero got=%b exp=11000", got_ctl()); end
    tick();
    drive(5'd1, 5'd7, 1, 0, 1, 5'd7, 0, 0, 0);
    total++; if (got_ctl() !== 5'b11000) begin bad++; $display("FAIL rt_unused got=%b exp=11000", got_ctl()); end
    tick();
    drive(5'd1, 5'd7, 0, 1, 1, 5'd7, 0, 0, 0);
    total++; if (got_ctl() !== 5'b00010) begin bad++; $display("FAIL rt_used got=%b exp=00010", got_ctl()); end
    tick();
  endtask

  task automatic test_branch_priority();
    drive(5'd3, 5'd3, 1, 1, 1, 5'd3, 1, 1, 0);
    total++; if (got_ctl() !== 5'b11110) begin bad++; $display("FAIL br_prio got=%b exp=11110", got_ctl()); end
    tick();
    drive(5'd3, 5'd4, 0, 0, 0, 5'd0, 0, 1, 0);
    total++; if (got_ctl() !== 5'b11100) begin bad++; $display("FAIL jump got=%b exp=11100", got_ctl()); end
    tick();
  endtask

  task automatic test_busy_load_use();
    for (int i = 0; i < 3; i++) begin
      drive(5'd6, 5'd0, 1, 0, 1, 5'd6, 0, 0, 1);
      total++; if (got_ctl() !== 5'b00001) begin bad++; $display("FAIL busy_hold%0d got=%b exp=00001", i, got_ctl()); end
      tick();
      total++; if (ctrl_state !== 2'd1) begin bad++; $display("FAIL busy_state%0d got=%0d exp=1", i, ctrl_state); end
    end
    drive(5'd6, 5'd0, 1, 0, 1, 5'd6, 0, 0, 0);
    total++; if (got_ctl() !== 5'b00010) begin bad++; $display("FAIL busy_then_lu got=%b exp=00010", got_ctl()); end
    tick();
    total++; if (ctrl_state !== 2'd0) begin bad++; $display("FAIL busy_back_run got=%0d exp=0", ctrl_state); end
    drive(5'd6, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0);
    total++; if (got_ctl() !== 5'b11000) begin bad++; $display("FAIL busy_lu_done got=%b exp=11000", got_ctl()); end
    tick();
    total++; if (perf_stall_cnt !== m_perf) begin bad++; $display("FAIL busy_perf got=%0d exp=%0d", perf_stall_cnt, m_perf); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      total++; if (timeout_err !== m_tout) begin bad++; $display("FAIL tout_edge%0d got=%b exp=%b", i + 1, timeout_err, m_tout); end
    end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tout_set got=%b exp=1", timeout_err); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    total++; if (timeout_err !== 1'b1 || ctrl_state !== 2'd0) begin
      bad++; $display("FAIL tout_sticky got to=%b st=%0d exp 1 0", timeout_err, ctrl_state);
    end
    // async reset in the middle of a WAIT phase
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    #2 reset = 1; #1;
    total++; if (ctrl_state !== 2'd0 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL async_reset got st=%0d to=%b exp 0 0", ctrl_state, timeout_err);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk); reset = 0; #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
      total++; if (got_ctl() !== model_ctl()) begin
        bad++; $display("FAIL rand_ctl%0d got=%b exp=%b", n, got_ctl(), model_ctl());
      end
      tick();
      total++; if (ctrl_state !== m_state || timeout_err !== m_tout || perf_stall_cnt !== m_perf) begin
        bad++; $display("FAIL rand_regs%0d got st=%0d to=%b perf=%0d exp st=%0d to=%b perf=%0d",
                        n, ctrl_state, timeout_err, perf_stall_cnt, m_state, m_tout, m_perf);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_priority();
    test_busy_load_use();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
